audio_wave_master: RTL and testbench

Avalon-MM initiator that drives the audio codec interface's 16-bit register slave from the wave-generator side. It takes stereo sample pairs from a valid/ready stream and writes them to the DAC left/right FIFO registers, gated by status polling. When enabled, it also drains ADC sample pairs and presents them on a capture output. It sits between the wave generator core and the audio interface slave, replacing software polling.

---
 rtl/audio_wave_master_if.sv | 20 ++
 rtl/audio_wave_master.sv | 191 +++++++++++++++++++
 tb/tb_audio_wave_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_wave_master_if.sv
// Avalon-MM register bus between the wave master and the audio codec slave.
// Latency: none, plain wires; read data returns READ_LATENCY cycles after the strobe.
// Backpressure: none; the slave has no waitrequest and completes each access in its strobe cycle.
interface audio_wave_master_if;
  logic [2:0]  m_address;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;

  modport master (
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/audio_wave_master.sv
// Status-polling Avalon initiator: streams DAC pairs to the codec FIFOs and drains ADC pairs.
// Latency: 4 cycles per DAC pair, 6 cycles from poll to adc_valid (READ_LATENCY = 1).
// Backpressure: sample_ready drops while a pair is held; the ADC output has no backpressure.
module audio_wave_master #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        adc_enable,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_left,
  input  logic [15:0] sample_right,
  output logic        adc_valid,
  output logic [15:0] adc_left,
  output logic [15:0] adc_right,
  output logic        busy,
  output logic [31:0] pair_count,
  audio_wave_master_if.master m
);

  typedef enum logic [3:0] {
    IDLE, CLR, POLL, PWAIT, GAP, WRL, WRR, RDL, RLWAIT, RDR, RRWAIT
  } state_t;

  // Zero latency means read data is taken on the same edge that samples the strobe.
  localparam bit         RL0      = (READ_LATENCY == 0);
  localparam bit         GAP0     = (POLL_GAP == 0);
  localparam logic [7:0] RL_INIT  = 8'(READ_LATENCY - 1);
  localparam logic [7:0] GAP_INIT = 8'(POLL_GAP - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] hold_q;
  logic        hold_v_q;
  logic        stop_pend_q;
  logic        first_q;
  logic [31:0] pair_count_q;
  logic        m_read_q;
  logic        m_write_q;
  logic [2:0]  m_address_q;
  logic [15:0] m_writedata_q;
  logic        adc_valid_q;
  logic [15:0] adc_left_q;
  logic [15:0] adc_right_q;

  logic rd_fin;
  logic poll_dec;
  logic do_wr;
  logic do_rd;
  logic go_poll;
  logic take;

  assign busy         = (state_q != IDLE);
  assign sample_ready = ~hold_v_q & busy;
  assign take         = sample_valid & sample_ready;

  // Read data is present on this edge: either the strobe edge itself or the end of the wait.
  assign rd_fin   = RL0 ? (state_q inside {POLL, RDL, RDR})
                        : ((state_q inside {PWAIT, RLWAIT, RRWAIT}) && (cnt_q == 8'd0));
  assign poll_dec = rd_fin && (state_q inside {POLL, PWAIT});
  assign do_wr    = hold_v_q & ~m.m_readdata[0];
  assign do_rd    = adc_enable & ~m.m_readdata[1];

  // Every path that re-enters POLL; stop is only honoured here so an L/R pair never splits.
  assign go_poll = (state_q == CLR) || (state_q == WRR) ||
                   ((state_q == GAP) && (cnt_q == 8'd0)) ||
                   (rd_fin && (state_q inside {RDR, RRWAIT})) ||
                   (poll_dec && !do_wr && !do_rd && GAP0);

  assign m.m_read      = m_read_q;
  assign m.m_write     = m_write_q;
  assign m.m_address   = m_address_q;
  assign m.m_writedata = m_writedata_q;
  assign adc_valid     = adc_valid_q;
  assign adc_left      = adc_left_q;
  assign adc_right     = adc_right_q;
  assign pair_count    = pair_count_q;

  // Sequencer: state, holding register and all registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      hold_q        <= 32'd0;
      hold_v_q      <= 1'b0;
      stop_pend_q   <= 1'b0;
      first_q       <= 1'b0;
      pair_count_q  <= 32'd0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= 3'd0;
      m_writedata_q <= 16'd0;
      adc_valid_q   <= 1'b0;
      adc_left_q    <= 16'd0;
      adc_right_q   <= 16'd0;
    end else begin
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      adc_valid_q <= 1'b0;
      if (stop && busy) stop_pend_q <= 1'b1;
      if (take) begin
        hold_q   <= {sample_left, sample_right};
        hold_v_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q       <= CLR;
          m_write_q     <= 1'b1;
          m_address_q   <= 3'd4;
          m_writedata_q <= 16'h0001;
          pair_count_q  <= 32'd0;
          first_q       <= 1'b1;
          stop_pend_q   <= stop;
        end
        POLL, PWAIT: begin
          if (poll_dec) begin
            if (do_wr) begin
              state_q       <= WRL;
              m_write_q     <= 1'b1;
              m_address_q   <= 3'd0;
              m_writedata_q <= hold_q[31:16];
            end else if (do_rd) begin
              state_q     <= RDL;
              m_read_q    <= 1'b1;
              m_address_q <= 3'd2;
            end else if (!GAP0) begin
              state_q <= GAP;
              cnt_q   <= GAP_INIT;
            end
          end else if (state_q == POLL) begin
            state_q <= PWAIT;
            cnt_q   <= RL_INIT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        WRL: begin
          state_q       <= WRR;
          m_write_q     <= 1'b1;
          m_address_q   <= 3'd1;
          m_writedata_q <= hold_q[15:0];
          hold_v_q      <= 1'b0;
          pair_count_q  <= pair_count_q + 32'd1;
        end
        GAP: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        RDL, RLWAIT: begin
          if (rd_fin) begin
            adc_left_q  <= m.m_readdata;
            state_q     <= RDR;
            m_read_q    <= 1'b1;
            m_address_q <= 3'd3;
          end else if (state_q == RDL) begin
            state_q <= RLWAIT;
            cnt_q   <= RL_INIT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RDR, RRWAIT: begin
          if (rd_fin) begin
            // The slave answers one read sequence late, so the first pair after start is stale.
            adc_right_q <= m.m_readdata;
            adc_valid_q <= ~first_q;
            first_q     <= 1'b0;
          end else if (state_q == RDR) begin
            state_q <= RRWAIT;
            cnt_q   <= RL_INIT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
      if (go_poll) begin
        if (stop_pend_q || stop) begin
          state_q     <= IDLE;
          stop_pend_q <= 1'b0;
        end else begin
          state_q     <= POLL;
          m_read_q    <= 1'b1;
          m_address_q <= 3'd5;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_wave_master.sv
// Bench for audio_wave_master: codec slave model plus write/ADC scoreboards.
// Latency: checks DAC pair spacing, poll period and ADC poll-to-valid timing.
// Backpressure: drives sample stream with valid held until ready.
module tb_audio_wave_master;
  localparam int RL = 1;
  localparam int PG = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        adc_enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left = 16'd0;
  logic [15:0] sample_right = 16'd0;
  logic        sample_ready;
  logic        adc_valid;
  logic [15:0] adc_left;
  logic [15:0] adc_right;
  logic        busy;
  logic [31:0] pair_count;

  audio_wave_master_if bus();

  audio_wave_master #(.READ_LATENCY(RL), .POLL_GAP(PG)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .adc_enable   (adc_enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .adc_valid    (adc_valid),
    .adc_left     (adc_left),
    .adc_right    (adc_right),
    .busy         (busy),
    .pair_count   (pair_count),
    .m            (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Codec slave: STATUS from dac_full and the ADC fill level, ADC data from tables.
  logic        dac_full = 1'b0;
  int          adc_lim = 0;
  int          adc_idx = 0;
  logic [15:0] adc_l_tbl [4];
  logic [15:0] adc_r_tbl [4];
  logic [15:0] rdata = 16'd0;
  logic [15:0] sd;
  assign bus.m_readdata = rdata;

  always @(negedge clk) begin
    if (bus.m_read) begin
      case (bus.m_address)
        3'd5: sd = {14'd0, (adc_idx >= adc_lim), dac_full};
        3'd2: sd = adc_l_tbl[adc_idx % 4];
        3'd3: begin
          sd = adc_r_tbl[adc_idx % 4];
          adc_idx++;
        end
        default: sd = 16'h0000;
      endcase
      @(posedge clk);
      #1 rdata = sd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboards and bus monitor.
  logic [18:0] wq[$];
  logic [31:0] aq[$];
  logic [18:0] ew;
  logic [31:0] ea;
  int wr_cnt = 0, adc_cnt = 0;
  int last_poll = 0, prev_poll = 0;
  int w0_prev = 0, w0_last = 0, w0_gap = 0, rdl_cyc = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_write) begin
        ew = (wq.size() != 0) ? wq.pop_front() : 19'h7FFFF;
        check("bus_write", {bus.m_address, bus.m_writedata}, ew);
        check("rw_excl", bus.m_read, 1'b0);
        wr_cnt++;
        if (bus.m_address == 3'd0) begin
          w0_prev = w0_last;
          w0_last = cyc;
          w0_gap  = cyc - last_poll;
        end
        if (bus.m_address == 3'd1) check("lr_b2b", cyc - w0_last, 1);
      end
      if (bus.m_read && bus.m_address == 3'd5) begin
        prev_poll = last_poll;
        last_poll = cyc;
      end
      if (bus.m_read && bus.m_address == 3'd2) rdl_cyc = cyc;
      if (adc_valid) begin
        ea = (aq.size() != 0) ? aq.pop_front() : 32'hDEADBEEF;
        check("adc_pair", {adc_left, adc_right}, ea);
        check("adc_lat", cyc - rdl_cyc, 4);
        adc_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int k = 0;
    wq.push_back({3'd0, l});
    wq.push_back({3'd1, r});
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", sample_ready, 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] n);
    int k = 0;
    while (pair_count !== n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("pair_count", pair_count, n);
  endtask

  task automatic pulse_start();
    wq.push_back({3'd4, 16'h0001});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    adc_l_tbl[0] = 16'h0000; adc_r_tbl[0] = 16'h0000;
    adc_l_tbl[1] = 16'h1111; adc_r_tbl[1] = 16'h2222;
    adc_l_tbl[2] = 16'h3333; adc_r_tbl[2] = 16'h4444;
    adc_l_tbl[3] = 16'h5555; adc_r_tbl[3] = 16'h6666;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_bus", {bus.m_read, bus.m_write, bus.m_address, bus.m_writedata}, 0);
    check("rst_rdy", sample_ready, 1'b0);
    check("rst_adc", {adc_valid, adc_left, adc_right}, 0);
    check("rst_pc", pair_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Start: CMD clear write then status poll
    pulse_start();
    check("start_busy", busy, 1'b1);
    check("clr_write", {bus.m_write, bus.m_address}, {1'b1, 3'd4});
    @(negedge clk);
    check("first_poll", {bus.m_read, bus.m_write, bus.m_address}, {1'b1, 1'b0, 3'd5});

    // Two DAC pairs back to back
    send(16'h1234, 16'hABCD);
    send(16'h0001, 16'hFFFF);
    wait_pc(2);
    @(negedge clk);
    check("dac_period", w0_last - w0_prev, 4);
    check("wq_dac", wq.size(), 0);

    // DAC FIFO full with a pair held
    dac_full = 1'b1;
    @(negedge clk);
    send(16'h5555, 16'hAAAA);
    base = wr_cnt;
    repeat (20) @(negedge clk);
    check("full_nowrite", wr_cnt, base);
    check("full_rdy", sample_ready, 1'b0);
    check("poll_period", last_poll - prev_poll, 2 + PG);
    dac_full = 1'b0;
    wait_pc(3);
    @(negedge clk);
    check("release_lat", w0_gap, 2);

    // ADC capture: first pair discarded
    adc_enable = 1'b1;
    adc_lim = 2;
    aq.push_back({16'h1111, 16'h2222});
    base = adc_cnt;
    k = 0;
    while (adc_idx < 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("adc_count", adc_cnt - base, 1);
    check("aq_empty", aq.size(), 0);
    adc_enable = 1'b0;

    // Stop during WRL: pair completes, then IDLE
    send(16'h0BAD, 16'hCAFE);
    k = 0;
    while (!(bus.m_write && bus.m_address == 3'd0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wrl_seen", {bus.m_write, bus.m_address}, {1'b1, 3'd0});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("wrr_after_stop", {bus.m_write, bus.m_address, bus.m_writedata}, {1'b1, 3'd1, 16'hCAFE});
    @(negedge clk);
    check("stop_idle", {busy, sample_ready}, 2'b00);
    check("stop_pc", pair_count, 4);

    // Reset during RLWAIT
    pulse_start();
    adc_enable = 1'b1;
    adc_lim = adc_idx + 1;
    k = 0;
    while (!(bus.m_read && bus.m_address == 3'd2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rdl_seen", {bus.m_read, bus.m_address}, {1'b1, 3'd2});
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_bus", {bus.m_read, bus.m_write, bus.m_address, bus.m_writedata}, 0);
    check("midrst_busy", {busy, sample_ready}, 2'b00);
    check("midrst_adc", {adc_valid, adc_left, adc_right}, 0);
    check("midrst_pc", pair_count, 0);
    adc_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // pair_count wrap
    pulse_start();
    repeat (3) @(negedge clk);
    force dut.pair_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pair_count_q;
    @(negedge clk);
    check("pc_preload", pair_count, 32'hFFFF_FFFF);
    send(16'hCAFE, 16'hF00D);
    wait_pc(0);
    @(negedge clk);
    check("wq_end", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
